pc_seq: RTL and testbench

- Next-PC sequencer that drives the PC register's control inputs: `pc_clr`, `pc_inc`, `branch_taken`, `abs_addr` and `branch_addr`.
- Arbitrates between decode-stage control, hazard-unit stall requests and halt/resume.
- Holds a redirect (taken branch or jump) that arrives during a stall until fetch can resume.
- Keeps saturating performance counters.
- PC values are word addresses. PC_INC codes come from defines.vh: NORMAL=00, BRANCH=01, JUMP=10, STOP=11.

---
 rtl/pc_seq_if.sv | 40 ++++
 rtl/pc_seq.sv | 159 +++++++++++++++
 tb/tb_pc_seq.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pc_seq_if.sv
// Bundle between the decode/hazard side and the next-PC sequencer.
// master drives decode and requests; slave (pc_seq) returns PC controls and counters.
interface pc_seq_if #(
  parameter int unsigned CNT_W = 32
);
  logic             id_valid;
  logic [1:0]       id_pc_inc;
  logic             id_branch_taken;
  logic [31:0]      id_abs_addr;
  logic [31:0]      id_branch_off;
  logic             stall_req;
  logic             halt_req;
  logic             resume;

  logic             pc_clr;
  logic [1:0]       pc_inc;
  logic             branch_taken;
  logic [31:0]      abs_addr;
  logic [31:0]      branch_addr;
  logic             flush;
  logic             halted;
  logic             running;
  logic [CNT_W-1:0] cyc_cnt;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] redirect_cnt;

  modport master (
    output id_valid, id_pc_inc, id_branch_taken, id_abs_addr, id_branch_off,
    output stall_req, halt_req, resume,
    input  pc_clr, pc_inc, branch_taken, abs_addr, branch_addr, flush,
    input  halted, running, cyc_cnt, stall_cnt, redirect_cnt
  );

  modport slave (
    input  id_valid, id_pc_inc, id_branch_taken, id_abs_addr, id_branch_off,
    input  stall_req, halt_req, resume,
    output pc_clr, pc_inc, branch_taken, abs_addr, branch_addr, flush,
    output halted, running, cyc_cnt, stall_cnt, redirect_cnt
  );
endinterface

// File: rtl/pc_seq.sv
// Next-PC sequencer: arbitrates decode redirects, stalls and halt/resume into PC controls,
// parking a redirect that arrives while fetch is held, and keeps saturating perf counters.
module pc_seq #(
  parameter int unsigned BOOT_CYCLES = 4,
  parameter int unsigned CNT_W       = 32
) (
  input logic     i_clk,
  input logic     i_clr_n,
  pc_seq_if.slave io_bus
);

  localparam logic [1:0] PcNormal = 2'b00;
  localparam logic [1:0] PcBranch = 2'b01;
  localparam logic [1:0] PcJump   = 2'b10;
  localparam logic [1:0] PcStop   = 2'b11;

  localparam int unsigned      BootW    = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
  localparam logic [BootW-1:0] BootLast = BootW'(BOOT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CntMax   = '1;

  typedef enum logic [1:0] {StBoot, StRun, StStall, StHalt} state_e;

  state_e             r_state;
  state_e             w_state_d;
  logic [BootW-1:0]   r_boot_cnt;
  logic               r_pend_valid;
  logic [1:0]         r_pend_inc;
  logic [31:0]        r_pend_abs;
  logic [31:0]        r_pend_off;
  logic [CNT_W-1:0]   r_cyc_cnt;
  logic [CNT_W-1:0]   r_stall_cnt;
  logic [CNT_W-1:0]   r_redir_cnt;

  logic               w_redirect;
  logic               w_capture;
  logic               w_pend_clr;
  logic               w_stall_inc;
  logic               w_redir_inc;
  logic               w_pc_clr;
  logic [1:0]         w_pc_inc;
  logic               w_branch_taken;
  logic [31:0]        w_abs_addr;
  logic [31:0]        w_branch_addr;
  logic               w_flush;

  assign w_redirect = io_bus.id_valid &
                      ((io_bus.id_pc_inc == PcJump) ||
                       ((io_bus.id_pc_inc == PcBranch) && io_bus.id_branch_taken));

  always_comb begin
    w_state_d      = r_state;
    w_pc_clr       = 1'b0;
    w_pc_inc       = PcStop;
    w_branch_taken = 1'b0;
    w_abs_addr     = r_pend_valid ? r_pend_abs : io_bus.id_abs_addr;
    w_branch_addr  = r_pend_valid ? r_pend_off : io_bus.id_branch_off;
    w_flush        = 1'b0;
    w_capture      = 1'b0;
    w_pend_clr     = 1'b0;
    w_stall_inc    = 1'b0;
    w_redir_inc    = 1'b0;

    unique case (r_state)
      StBoot: begin
        w_pc_clr = 1'b1;
        w_flush  = 1'b1;
        if (r_boot_cnt == BootLast) w_state_d = StRun;
      end
      StRun: begin
        if (io_bus.halt_req) begin
          w_capture = w_redirect;
          w_state_d = StHalt;
        end else if (io_bus.stall_req) begin
          w_capture   = w_redirect;
          w_stall_inc = 1'b1;
          w_state_d   = StStall;
        end else if (r_pend_valid) begin
          // Parked redirect goes out first; this cycle's decode fields are dropped.
          w_pc_inc       = r_pend_inc;
          w_branch_taken = 1'b1;
          w_flush        = 1'b1;
          w_pend_clr     = 1'b1;
          w_redir_inc    = 1'b1;
        end else begin
          w_pc_inc       = io_bus.id_valid ? io_bus.id_pc_inc : PcNormal;
          w_branch_taken = io_bus.id_valid & io_bus.id_branch_taken;
          w_flush        = w_redirect;
          w_redir_inc    = w_redirect;
        end
      end
      StStall: begin
        w_capture = w_redirect;
        if (io_bus.halt_req) begin
          w_state_d = StHalt;
        end else if (!io_bus.stall_req) begin
          w_state_d = StRun;
        end else begin
          w_stall_inc = 1'b1;
        end
      end
      StHalt: begin
        if (io_bus.resume && !io_bus.halt_req) w_state_d = StRun;
      end
      default: w_state_d = StBoot;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_clr_n) begin
      r_state    <= StBoot;
      r_boot_cnt <= '0;
    end else begin
      r_state <= w_state_d;
      if (r_state == StBoot) r_boot_cnt <= r_boot_cnt + 1'b1;
    end
  end

  // Oldest redirect wins: a new one is latched only into an empty slot.
  always_ff @(posedge i_clk) begin
    if (!i_clr_n) begin
      r_pend_valid <= 1'b0;
      r_pend_inc   <= PcNormal;
      r_pend_abs   <= '0;
      r_pend_off   <= '0;
    end else if (w_pend_clr) begin
      r_pend_valid <= 1'b0;
    end else if (w_capture && !r_pend_valid) begin
      r_pend_valid <= 1'b1;
      r_pend_inc   <= io_bus.id_pc_inc;
      r_pend_abs   <= io_bus.id_abs_addr;
      r_pend_off   <= io_bus.id_branch_off;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_clr_n) begin
      r_cyc_cnt   <= '0;
      r_stall_cnt <= '0;
      r_redir_cnt <= '0;
    end else begin
      if ((r_state != StBoot) && (r_cyc_cnt != CntMax)) r_cyc_cnt <= r_cyc_cnt + 1'b1;
      if (w_stall_inc && (r_stall_cnt != CntMax)) r_stall_cnt <= r_stall_cnt + 1'b1;
      if (w_redir_inc && (r_redir_cnt != CntMax)) r_redir_cnt <= r_redir_cnt + 1'b1;
    end
  end

  assign io_bus.pc_clr       = w_pc_clr;
  assign io_bus.pc_inc       = w_pc_inc;
  assign io_bus.branch_taken = w_branch_taken;
  assign io_bus.abs_addr     = w_abs_addr;
  assign io_bus.branch_addr  = w_branch_addr;
  assign io_bus.flush        = w_flush;
  assign io_bus.halted       = (r_state == StHalt);
  assign io_bus.running      = (r_state == StRun);
  assign io_bus.cyc_cnt      = r_cyc_cnt;
  assign io_bus.stall_cnt    = r_stall_cnt;
  assign io_bus.redirect_cnt = r_redir_cnt;

endmodule

// File: tb/tb_pc_seq.sv
// Bench for pc_seq: a full-width and a 4-bit-counter instance share one stimulus stream,
// checked every cycle against a behavioural model (mode + pending queue + unbounded counts).
module tb_pc_seq;
  localparam int unsigned BootCycles = 4;
  localparam int MBoot  = 0;
  localparam int MRun   = 1;
  localparam int MStall = 2;
  localparam int MHalt  = 3;

  logic clk;
  logic clr_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  pc_seq_if #(.CNT_W(32)) bus ();
  pc_seq_if #(.CNT_W(4))  bus_s ();

  pc_seq #(.BOOT_CYCLES(BootCycles), .CNT_W(32)) u_dut (
    .i_clk  (clk),
    .i_clr_n(clr_n),
    .io_bus (bus)
  );

  pc_seq #(.BOOT_CYCLES(BootCycles), .CNT_W(4)) u_dut_s (
    .i_clk  (clk),
    .i_clr_n(clr_n),
    .io_bus (bus_s)
  );

  logic        s_valid, s_taken, s_stall, s_halt, s_resume;
  logic [1:0]  s_inc;
  logic [31:0] s_abs, s_off;

  assign bus.id_valid          = s_valid;
  assign bus.id_pc_inc         = s_inc;
  assign bus.id_branch_taken   = s_taken;
  assign bus.id_abs_addr       = s_abs;
  assign bus.id_branch_off     = s_off;
  assign bus.stall_req         = s_stall;
  assign bus.halt_req          = s_halt;
  assign bus.resume            = s_resume;
  assign bus_s.id_valid        = s_valid;
  assign bus_s.id_pc_inc       = s_inc;
  assign bus_s.id_branch_taken = s_taken;
  assign bus_s.id_abs_addr     = s_abs;
  assign bus_s.id_branch_off   = s_off;
  assign bus_s.stall_req       = s_stall;
  assign bus_s.halt_req        = s_halt;
  assign bus_s.resume          = s_resume;

  typedef struct {
    logic [1:0]  inc;
    logic [31:0] abs;
    logic [31:0] off;
  } pend_t;

  int     total = 0;
  int     bad   = 0;
  int     m_mode = MBoot;
  int     m_boot_left = BootCycles;
  pend_t  pend_q[$];
  longint m_cyc = 0, m_stall = 0, m_redir = 0;

  logic        o_clr, o_bt, o_flush, o_halted, o_running;
  logic [1:0]  o_inc;
  logic [31:0] o_abs, o_baddr;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] sat(input longint v, input int w);
    longint mx;
    mx = (64'sd1 <<< w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  task automatic drive(input logic v, input logic [1:0] inc, input logic t,
                       input logic [31:0] abs, input logic [31:0] off,
                       input logic st, input logic h, input logic r);
    s_valid = v; s_inc = inc; s_taken = t; s_abs = abs; s_off = off;
    s_stall = st; s_halt = h; s_resume = r;
  endtask

  // One clock: check combinational outputs at negedge, advance model at posedge, check counters.
  task automatic step();
    logic        redir, have_p, e_clr, e_bt, e_flush;
    logic [1:0]  e_inc;
    logic [31:0] e_abs, e_baddr;
    int          nxt;
    bit          push, pop;
    int          d_stall, d_redir;
    @(negedge clk);
    o_clr = bus.pc_clr; o_inc = bus.pc_inc; o_bt = bus.branch_taken; o_abs = bus.abs_addr;
    o_baddr = bus.branch_addr; o_flush = bus.flush; o_halted = bus.halted;
    o_running = bus.running;
    redir  = s_valid && ((s_inc == 2'b10) || ((s_inc == 2'b01) && s_taken));
    have_p = (pend_q.size() != 0);
    e_clr = 1'b0; e_inc = 2'b11; e_bt = 1'b0; e_flush = 1'b0;
    e_abs   = have_p ? pend_q[0].abs : s_abs;
    e_baddr = have_p ? pend_q[0].off : s_off;
    nxt = m_mode; push = 0; pop = 0; d_stall = 0; d_redir = 0;
    case (m_mode)
      MBoot: begin e_clr = 1'b1; e_flush = 1'b1; end
      MRun: begin
        if (s_halt) begin
          push = redir; nxt = MHalt;
        end else if (s_stall) begin
          push = redir; nxt = MStall; d_stall = 1;
        end else if (have_p) begin
          e_inc = pend_q[0].inc; e_bt = 1'b1; e_flush = 1'b1; pop = 1; d_redir = 1;
        end else begin
          e_inc = s_valid ? s_inc : 2'b00;
          e_bt = s_valid & s_taken;
          e_flush = redir;
          d_redir = redir ? 1 : 0;
        end
      end
      MStall: begin
        push = redir;
        if (s_halt) nxt = MHalt;
        else if (!s_stall) nxt = MRun;
        else d_stall = 1;
      end
      default: if (s_resume && !s_halt) nxt = MRun;
    endcase
    if (clr_n) begin
      chk("pc_clr", o_clr, e_clr);
      chk("pc_inc", o_inc, e_inc);
      chk("branch_taken", o_bt, e_bt);
      chk("abs_addr", o_abs, e_abs);
      chk("branch_addr", o_baddr, e_baddr);
      chk("flush", o_flush, e_flush);
      chk("halted", o_halted, m_mode == MHalt);
      chk("running", o_running, m_mode == MRun);
    end
    @(posedge clk);
    if (!clr_n) begin
      m_mode = MBoot; m_boot_left = BootCycles; pend_q.delete();
      m_cyc = 0; m_stall = 0; m_redir = 0;
    end else begin
      if (m_mode != MBoot) m_cyc++;
      if (m_mode == MBoot) begin
        m_boot_left--;
        if (m_boot_left == 0) nxt = MRun;
      end
      if (pop) void'(pend_q.pop_front());
      if (push && pend_q.size() == 0) pend_q.push_back('{inc: s_inc, abs: s_abs, off: s_off});
      m_stall += d_stall;
      m_redir += d_redir;
      m_mode = nxt;
    end
    #1;
    chk("cyc_cnt", bus.cyc_cnt, sat(m_cyc, 32));
    chk("stall_cnt", bus.stall_cnt, sat(m_stall, 32));
    chk("redirect_cnt", bus.redirect_cnt, sat(m_redir, 32));
    chk("cyc_cnt_w4", bus_s.cyc_cnt, sat(m_cyc, 4));
    chk("stall_cnt_w4", bus_s.stall_cnt, sat(m_stall, 4));
    chk("redirect_cnt_w4", bus_s.redirect_cnt, sat(m_redir, 4));
  endtask

  initial begin
    clr_n = 1'b0;
    drive(0, 2'b00, 0, 0, 0, 0, 0, 0);
    step(); step();
    clr_n = 1'b1;
    for (int i = 0; i < int'(BootCycles); i++) begin
      step();
      chk("boot_pc_clr", o_clr, 1'b1);
    end
    repeat (3) step();
    chk("boot_done_running", o_running, 1'b1);
    chk("boot_done_inc", o_inc, 2'b00);
    chk("boot_cyc3", bus.cyc_cnt, 64'd3);

    // Taken branch back 3 words, then not-taken
    drive(1, 2'b01, 1, 0, 32'hFFFF_FFFD, 0, 0, 0);
    step();
    chk("br_inc", o_inc, 2'b01);
    chk("br_taken", o_bt, 1'b1);
    chk("br_addr", o_baddr, 32'hFFFF_FFFD);
    chk("br_flush", o_flush, 1'b1);
    chk("br_redir_cnt", bus.redirect_cnt, 64'd1);
    drive(1, 2'b01, 0, 0, 32'hFFFF_FFFD, 0, 0, 0);
    step();
    chk("br_nt_flush", o_flush, 1'b0);

    // Jump parked during stall; later jump ignored
    drive(1, 2'b10, 0, 32'h40, 0, 1, 0, 0); step();
    chk("stl_inc0", o_inc, 2'b11);
    drive(1, 2'b10, 0, 32'h80, 0, 1, 0, 0); step();
    chk("stl_inc1", o_inc, 2'b11);
    drive(0, 2'b00, 0, 0, 0, 1, 0, 0); step();
    chk("stl_inc2", o_inc, 2'b11);
    drive(0, 2'b00, 0, 0, 0, 0, 0, 0); step();
    step();
    chk("stl_issue_inc", o_inc, 2'b10);
    chk("stl_issue_abs", o_abs, 32'h40);
    chk("stl_issue_flush", o_flush, 1'b1);
    chk("stl_cnt3", bus.stall_cnt, 64'd3);

    // Parked branch survives halt; resume with halt_req held stays halted
    drive(1, 2'b01, 1, 0, 32'd5, 1, 0, 0); step();
    drive(0, 2'b00, 0, 0, 0, 1, 1, 0); step();
    drive(0, 2'b00, 0, 0, 0, 0, 1, 1); step();
    chk("halt_held", o_halted, 1'b1);
    drive(0, 2'b00, 0, 0, 0, 0, 0, 1); step();
    chk("halt_resume", o_halted, 1'b1);
    drive(0, 2'b00, 0, 0, 0, 0, 0, 0); step();
    chk("resume_running", o_running, 1'b1);
    chk("resume_inc", o_inc, 2'b01);
    chk("resume_baddr", o_baddr, 32'd5);

    // Reset while stalled with a parked jump discards it
    drive(1, 2'b10, 0, 32'h40, 0, 1, 0, 0); step();
    drive(0, 2'b00, 0, 0, 0, 1, 0, 0);
    clr_n = 1'b0; step();
    clr_n = 1'b1;
    drive(0, 2'b00, 0, 0, 0, 0, 0, 0);
    repeat (BootCycles) step();
    drive(1, 2'b00, 0, 32'h123, 0, 0, 0, 0); step();
    chk("rst_first_inc", o_inc, 2'b00);
    chk("rst_first_flush", o_flush, 1'b0);

    // 20 stall cycles saturate the 4-bit counter
    drive(0, 2'b00, 0, 0, 0, 1, 0, 0);
    repeat (20) step();
    chk("sat_stall_w4", bus_s.stall_cnt, 64'd15);
    chk("sat_stall_w32", bus.stall_cnt, 64'd20);
    drive(0, 2'b00, 0, 0, 0, 0, 0, 0); step(); step();

    for (int i = 0; i < 400; i++) begin
      clr_n = ($urandom_range(99) != 0);
      drive($urandom_range(1), 2'($urandom_range(3)), $urandom_range(1), $urandom, $urandom,
            $urandom_range(3) == 0, $urandom_range(9) == 0, $urandom_range(2) == 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
